// File: rtl/victim_cache_types.sv
// Shared types and constants for the victim cache control slice.
//   vc_state_t      : sequencing FSM states
//   VC_*            : default line geometry (32-byte lines, 16 sets, 32-bit addresses)
//   vc_align_mask() : clears the byte-offset bits of a line address
//   vc_low_mask()   : selects the low index+offset bits of an address
package victim_cache_types;

    localparam int unsigned VC_OFFSET = 5;
    localparam int unsigned VC_INDEX  = 4;
    localparam int unsigned VC_TAG    = 32 - VC_OFFSET - VC_INDEX;
    localparam int unsigned VC_MASK   = 2 ** VC_OFFSET;

    localparam logic [VC_MASK-1:0] VC_FULL_MASK = '1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CHECK,
        SWAP,
        WB,
        FETCH,
        INSTALL,
        DONE
    } vc_state_t;

    function automatic logic [31:0] vc_align_mask(input int unsigned off);
        return ~((32'd1 << off) - 32'd1);
    endfunction

    function automatic logic [31:0] vc_low_mask(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/vc_perf_counters.sv
// Saturating event counter trio for the victim cache controller.
//   clk, rst                        : clock, asynchronous active-high reset
//   hit_inc, miss_inc, wb_inc       : single-cycle increment strobes
//   hit_count, miss_count, wb_count : 32-bit counts, stick at all-ones
module vc_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit_inc,
    input  logic        miss_inc,
    input  logic        wb_inc,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_inc && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_inc && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
            if (wb_inc && (wb_count != 32'hFFFF_FFFF)) begin
                wb_count <= wb_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/victim_cache_control.sv
// Sequencing FSM for a direct-mapped victim cache (one victim line per set).
// On a main-cache miss it probes the victim slot and either swaps lines with the
// main cache, or writes back a dirty victim, fetches from memory and installs the
// evicted main line into the victim slot.
//
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   req                          : miss service request (level, held until resp)
//   mem_address                  : missing line address
//   cache_valid                  : evicted main-cache line is valid
//   victim_hit / victim_*_o      : victim probe results from the datapath
//   pmem_resp                    : memory transaction complete
//   victim_*_we, mask_val        : datapath write enables and byte mask
//   data_in_sel                  : 0 = memory path, 1 = main-cache path
//   pmem_read/pmem_write/address : memory line transaction
//   resp, line_src               : completion pulse; 1 = line came from victim
//
// Build option: define VICTIM_PERF_CNT_EN to add hit_count, miss_count, wb_count.
module victim_cache_control
    import victim_cache_types::*;
#(
    parameter int unsigned s_offset = VC_OFFSET,
    parameter int unsigned s_index  = VC_INDEX,
    parameter int unsigned s_tag    = 32 - s_offset - s_index,
    parameter int unsigned s_mask   = 2 ** s_offset
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [31:0]       mem_address,
    input  logic              cache_valid,
    input  logic              victim_hit,
    input  logic              victim_valid_o,
    input  logic              victim_dirty_o,
    input  logic [s_tag-1:0]  victim_tag_o,
    input  logic              pmem_resp,
    output logic              victim_data_we,
    output logic              victim_tag_we,
    output logic              victim_dirty_we,
    output logic              victim_valid_we,
    output logic [s_mask-1:0] mask_val,
    output logic              data_in_sel,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic              resp,
    output logic              line_src
`ifdef VICTIM_PERF_CNT_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count,
    output logic [31:0]       wb_count
`endif
);

    localparam logic [31:0] AlignMask = vc_align_mask(s_offset);
    localparam logic [31:0] IndexMask = vc_low_mask(s_offset + s_index) & AlignMask;

    vc_state_t state_q, state_d;
    logic      line_src_q, line_src_d;

    logic [31:0] fetch_addr;
    logic [31:0] wb_addr;
    logic        probe_hit;

    assign fetch_addr = mem_address & AlignMask;
    // Write-back target: the victim's own tag with the current set index.
    assign wb_addr    = {victim_tag_o, {(s_offset + s_index){1'b0}}}
                      | (mem_address & IndexMask);
    assign probe_hit  = victim_valid_o & victim_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            line_src_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_src_q <= line_src_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        line_src_d      = 1'b0;
        victim_data_we  = 1'b0;
        victim_tag_we   = 1'b0;
        victim_dirty_we = 1'b0;
        victim_valid_we = 1'b0;
        mask_val        = '0;
        data_in_sel     = 1'b0;
        pmem_read       = 1'b0;
        pmem_write      = 1'b0;
        pmem_address    = '0;
        resp            = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) state_d = READ;
            end
            READ: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (probe_hit) begin
                    state_d = SWAP;
                end else if (victim_valid_o && victim_dirty_o) begin
                    state_d = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            SWAP: begin
                data_in_sel     = 1'b1;
                victim_data_we  = 1'b1;
                victim_tag_we   = 1'b1;
                victim_dirty_we = 1'b1;
                victim_valid_we = 1'b1;
                mask_val        = '1;
                line_src_d      = 1'b1;
                state_d         = DONE;
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = wb_addr;
                if (pmem_resp) state_d = FETCH;
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = fetch_addr;
                if (pmem_resp) state_d = INSTALL;
            end
            INSTALL: begin
                data_in_sel     = 1'b1;
                // An invalid evicted line only clears the victim valid bit.
                victim_valid_we = 1'b1;
                if (cache_valid) begin
                    victim_data_we  = 1'b1;
                    victim_tag_we   = 1'b1;
                    victim_dirty_we = 1'b1;
                    mask_val        = '1;
                end
                state_d = DONE;
            end
            DONE: begin
                resp    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign line_src = line_src_q;

`ifdef VICTIM_PERF_CNT_EN
    logic hit_inc, miss_inc, wb_inc;

    assign hit_inc  = (state_q == CHECK) && (state_d == SWAP);
    assign miss_inc = (state_q == CHECK) && (state_d != SWAP);
    assign wb_inc   = (state_q == WB) && pmem_resp;

    vc_perf_counters u_perf (
        .clk        (clk),
        .rst        (rst),
        .hit_inc    (hit_inc),
        .miss_inc   (miss_inc),
        .wb_inc     (wb_inc),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
    );
`endif

endmodule
